// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Add/shift/logic ops complete in one cycle; multiply and
// divide iterate radix-2 over WIDTH cycles on operand magnitudes with a final sign fixup.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES     = {WIDTH{1'b1}};
  localparam logic [SHW:0]       CNT_LOAD = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]       CNT_ONE  = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0]       CNT_ZERO = {(SHW+1){1'b0}};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    f_neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           r_state;
  logic [SHW:0]     r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_f;

  logic [SHW-1:0]     w_shamt;
  logic               w_a_sgn;
  logic               w_b_sgn;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH-1:0]   w_fast;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mhi;
  logic [WIDTH-1:0]   w_mlo;
  logic [WIDTH:0]     w_rs;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_dhi;
  logic [WIDTH-1:0]   w_dlo;
  logic [WIDTH-1:0]   w_nhi;
  logic [WIDTH-1:0]   w_nlo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_res;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_f     = r_f;

  // Operand conditioning at acceptance: signedness per opcode, then magnitudes.
  assign w_shamt = in_b[SHW-1:0];
  assign w_a_sgn = (in_op == 4'd9) || (in_op == 4'd10) || (in_op == 4'd12) || (in_op == 4'd14);
  assign w_b_sgn = (in_op == 4'd9) || (in_op == 4'd12) || (in_op == 4'd14);
  assign w_a_neg = w_a_sgn && in_a[WIDTH-1];
  assign w_b_neg = w_b_sgn && in_b[WIDTH-1];
  assign w_ma    = w_a_neg ? f_neg(in_a) : in_a;
  assign w_mb    = w_b_neg ? f_neg(in_b) : in_b;

  // Single-cycle results for opcodes 0-7.
  always_comb begin
    w_fast = ZERO;
    case (in_op[2:0])
      3'd0:    w_fast = in_a + in_b;
      3'd1:    w_fast = in_a << w_shamt;
      3'd2:    w_fast = $unsigned($signed(in_a) >>> w_shamt);
      3'd3:    w_fast = in_a - in_b;
      3'd4:    w_fast = in_a ^ in_b;
      3'd5:    w_fast = in_a >> w_shamt;
      3'd6:    w_fast = in_a | in_b;
      3'd7:    w_fast = in_a & in_b;
      default: w_fast = ZERO;
    endcase
  end

  // Shift-add step: {r_hi, r_lo} holds partial product over the unconsumed multiplier bits.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_ma} : {1'b0, ZERO});
  assign w_mhi     = w_mul_sum[WIDTH:1];
  assign w_mlo     = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // Restoring step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_rs   = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_rs - {1'b0, r_mb};
  assign w_dhi  = w_diff[WIDTH] ? w_rs[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_dlo  = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};

  assign w_nhi    = r_op[2] ? w_dhi : w_mhi;
  assign w_nlo    = r_op[2] ? w_dlo : w_mlo;
  assign w_prod   = {w_mhi, w_mlo};
  assign w_prod_s = r_neg_q ? (~w_prod + ONE_2W) : w_prod;

  // Final-cycle result with sign fixup and divide-by-zero override.
  always_comb begin
    w_res = ZERO;
    if (r_op[2] == 1'b0) begin
      if (r_op[1:0] == 2'd0) begin
        w_res = w_prod_s[WIDTH-1:0];
      end else begin
        w_res = w_prod_s[2*WIDTH-1:WIDTH];
      end
    end else begin
      case (r_op[1:0])
        2'd0:    w_res = r_dz ? ONES : (r_neg_q ? f_neg(w_dlo) : w_dlo);
        2'd1:    w_res = r_dz ? ONES : w_dlo;
        2'd2:    w_res = r_dz ? r_a : (r_neg_r ? f_neg(w_dhi) : w_dhi);
        2'd3:    w_res = r_dz ? r_a : w_dhi;
        default: w_res = ZERO;
      endcase
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_op    <= 3'd0;
      r_a     <= ZERO;
      r_ma    <= ZERO;
      r_mb    <= ZERO;
      r_hi    <= ZERO;
      r_lo    <= ZERO;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_f     <= ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            r_op    <= in_op[2:0];
            r_a     <= in_a;
            r_ma    <= w_ma;
            r_mb    <= w_mb;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= (in_b == ZERO);
            r_hi    <= ZERO;
            if (in_op[3]) begin
              r_lo    <= in_op[2] ? w_ma : w_mb;
              r_cnt   <= CNT_LOAD;
              r_state <= S_CALC;
            end else begin
              r_f     <= w_fast;
              r_state <= S_DONE;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_cnt   <= CNT_ZERO;
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_f     <= w_res;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (flush || out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32): hand-computed results, latencies,
// stall/flush/reset behaviour.
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] prev_f;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, then scramble the inputs; returns result and edges-to-DONE.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] f, output int lat);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = ~op; in_a = ~a; in_b = b ^ 32'h5A5A_A5A5;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    f = out_f;
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic check_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] f;
    int lat;
    run_op(op, a, b, f, lat);
    check_eq({tag, "_f"}, {32'd0, f}, {32'd0, exp});
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    prev_f = exp;
    consume(tag);
  endtask

  initial begin
    logic [31:0] f;
    int lat;
    logic seen;
    rst = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = 32'd0; in_b = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdy", {63'd0, in_ready}, 64'd1);
    check_eq("rst_vld", {63'd0, out_valid}, 64'd0);
    check_eq("rst_f", {32'd0, out_f}, 64'd0);
    rst = 1'b1;

    // First acceptance on the first edge after release.
    check_op("sub", 4'd3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    check_op("add", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1);
    check_op("sll", 4'd1, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1);
    check_op("sra", 4'd2, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1);
    check_op("srl", 4'd5, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1);
    check_op("xor", 4'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
    check_op("or",  4'd6, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    check_op("and", 4'd7, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);

    check_op("mulh",   4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    check_op("mulhu",  4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    check_op("mul",    4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    check_op("mulhsu", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    check_op("mul2",   4'd8,  32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
    check_op("mulh2",  4'd9,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);

    check_op("div",    4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    check_op("rem",    4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    check_op("div2",   4'd12, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    check_op("rem2",   4'd14, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    check_op("divu",   4'd13, 32'd100, 32'd7, 32'h0000_000E, 33);
    check_op("remu",   4'd15, 32'd100, 32'd7, 32'h0000_0002, 33);
    check_op("divu0",  4'd13, 32'd7, 32'd0, 32'hFFFF_FFFF, 33);
    check_op("remu0",  4'd15, 32'd7, 32'd0, 32'h0000_0007, 33);
    check_op("div0",   4'd12, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33);
    check_op("rem0",   4'd14, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33);
    check_op("divovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    check_op("removf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

    // Back-pressure: result held for 10 cycles.
    run_op(4'd4, 32'h1234_0000, 32'h0000_5678, f, lat);
    check_eq("stall_f0", {32'd0, f}, 64'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("stall_f", {32'd0, out_f}, 64'h1234_5678);
      check_eq("stall_rdy", {63'd0, in_ready}, 64'd0);
      check_eq("stall_vld", {63'd0, out_valid}, 64'd1);
    end
    prev_f = 32'h1234_5678;
    consume("stall");
    check_eq("stall_vld_off", {63'd0, out_valid}, 64'd0);

    // Flush mid-divide.
    in_valid = 1'b1; in_op = 4'd13; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check_eq("fl_busy", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("fl_rdy", {63'd0, in_ready}, 64'd1);
    check_eq("fl_f", {32'd0, out_f}, {32'd0, prev_f});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check_eq("fl_novld", {63'd0, seen}, 64'd0);

    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; flush = 1'b1; in_op = 4'd0; in_a = 32'd1; in_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_eq("fli_rdy", {63'd0, in_ready}, 64'd1);
    check_eq("fli_vld", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-multiply.
    in_valid = 1'b1; in_op = 4'd8; in_a = 32'd3; in_b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    check_eq("ar_f", {32'd0, out_f}, 64'd0);
    check_eq("ar_rdy", {63'd0, in_ready}, 64'd1);
    check_eq("ar_vld", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check_eq("ar_novld", {63'd0, seen}, 64'd0);
    check_op("post", 4'd0, 32'd1, 32'd1, 32'd2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
